// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC conversion sequencer.
package adc_seq_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      SPACE = 2'd3
   } state_t;

   localparam int PERIOD_MIN_DEF     = 4;
   localparam int TIMEOUT_CYCLES_DEF = 1024;
   localparam int ACC_W              = 19;
   localparam int DATA_W             = 16;

   function automatic logic [DATA_W-1:0] clamp_period(input logic [DATA_W-1:0] p,
                                                      input int unsigned       pmin);
      return (p < DATA_W'(pmin)) ? DATA_W'(pmin) : p;
   endfunction
endpackage

// File: rtl/adc_seq_avg.sv
// Sample accumulator for power-of-two averaging; publishes sum >> log2 when the set is complete.
module adc_seq_avg
   import adc_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic              sample_i,
   input  logic [1:0]        log2_i,
   input  logic [DATA_W-1:0] raw_i,
   output logic              at_bound_o,
   output logic              pub_o,
   output logic [DATA_W-1:0] pub_val_o
);
   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic [3:0]       cnt_q, cnt_d, cnt_n;
   logic [1:0]       n_q, n_d;

   assign sum        = acc_q + ACC_W'(raw_i);
   assign cnt_n      = cnt_q + 4'd1;
   assign at_bound_o = (cnt_q == 4'd0);
   assign pub_o      = sample_i && (cnt_n == (4'd1 << n_q));
   assign pub_val_o  = DATA_W'(sum >> n_q);

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      n_d   = n_q;
      // The averaging depth only changes between results.
      if (load_i && at_bound_o) n_d = log2_i;
      if (flush_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (sample_i) begin
         if (pub_o) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         n_q   <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         n_q   <= n_d;
      end
   end
endmodule

// File: rtl/adc_seq_ctrl.sv
// ADC conversion sequencer: periodic/single starts, timeout, overrun count.
// Averaging is built only when ADC_SEQ_AVG_EN is defined; otherwise every adc_done publishes adc_raw.
module adc_seq_ctrl
   import adc_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int PERIOD_MIN     = PERIOD_MIN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_enable,
   input  logic [DATA_W-1:0] cfg_period,
   input  logic              cfg_single,
   input  logic [1:0]        cfg_avg_log2,
   input  logic              err_clear,
   input  logic              adc_busy,
   input  logic              adc_done,
   input  logic [DATA_W-1:0] adc_raw,
   output logic              adc_start,
   output logic [DATA_W-1:0] adc_data_value,
   output logic              adc_data_valid,
   output logic              busy,
   output logic              err_timeout,
   output logic [7:0]        ovr_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] per_cnt_q, per_cnt_d, per_q, per_d, per_eff;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              pend_q, pend_d, err_q, err_d, dvld_q;
   logic [7:0]        ovr_q, ovr_d;
   logic [DATA_W-1:0] dval_q, dval_d, pub_val;
   logic              issue, sample, per_exp, tmo_evt, ovr_evt, cont, pub, at_bound;

   assign issue   = (state_q == START) && !adc_busy;
   assign sample  = (state_q == WAIT) && adc_done;
   // Counter holds 1 in the last cycle of the period, so the next START lands exactly on time.
   assign per_exp = (per_cnt_q <= DATA_W'(1));
   assign tmo_evt = (state_q == WAIT) && !adc_done && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign ovr_evt = (state_q == WAIT) && !adc_done && (per_cnt_q == DATA_W'(1));
   assign cont    = cfg_enable || (pend_q && !pub);
   assign per_eff = at_bound ? cfg_period : per_q;

`ifdef ADC_SEQ_AVG_EN
   logic flush;
   assign flush = (state_q != IDLE) && (state_d == IDLE);

   adc_seq_avg u_avg (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .load_i     (issue),
      .sample_i   (sample),
      .log2_i     (cfg_avg_log2),
      .raw_i      (adc_raw),
      .at_bound_o (at_bound),
      .pub_o      (pub),
      .pub_val_o  (pub_val)
   );
`else
   logic unused_avg;
   assign unused_avg = ^cfg_avg_log2;
   assign at_bound   = 1'b1;
   assign pub        = sample;
   assign pub_val    = adc_raw;
`endif

   always_comb begin
      state_d   = state_q;
      per_cnt_d = (per_cnt_q != '0) ? per_cnt_q - DATA_W'(1) : per_cnt_q;
      per_d     = per_q;
      tmo_d     = tmo_q;
      pend_d    = pend_q;
      err_d     = err_q;
      ovr_d     = ovr_q;
      dval_d    = dval_q;
      case (state_q)
         IDLE: if (!adc_busy && (cfg_enable || pend_q)) state_d = START;
         START: if (issue) begin
            per_d     = per_eff;
            per_cnt_d = clamp_period(per_eff, PERIOD_MIN) - DATA_W'(1);
            tmo_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (adc_done) state_d = (per_exp && cont && !adc_busy) ? START : SPACE;
            else if (tmo_evt) state_d = IDLE;
            else tmo_d = tmo_q + TW'(1);
         end
         SPACE: if (per_exp) begin
            if (!cont) state_d = IDLE;
            else if (!adc_busy) state_d = START;
         end
         default: state_d = IDLE;
      endcase
      if (pub) begin
         dval_d = pub_val;
         pend_d = 1'b0;
      end
      if (tmo_evt) pend_d = 1'b0;
      if (cfg_single && !cfg_enable) pend_d = 1'b1;
      if (err_clear) begin
         err_d = 1'b0;
         ovr_d = '0;
      end
      if (tmo_evt) err_d = 1'b1;
      if (ovr_evt && ovr_d != 8'hFF) ovr_d = ovr_d + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         per_cnt_q <= '0;
         per_q     <= '0;
         tmo_q     <= '0;
         pend_q    <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= '0;
         dval_q    <= '0;
         dvld_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_cnt_q <= per_cnt_d;
         per_q     <= per_d;
         tmo_q     <= tmo_d;
         pend_q    <= pend_d;
         err_q     <= err_d;
         ovr_q     <= ovr_d;
         dval_q    <= dval_d;
         dvld_q    <= pub;
      end
   end

   assign adc_start      = issue;
   assign adc_data_value = dval_q;
   assign adc_data_valid = dvld_q;
   assign busy           = (state_q != IDLE);
   assign err_timeout    = err_q;
   assign ovr_count      = ovr_q;
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl with a behavioural ADC responding to adc_start after a set latency.
module tb_adc_seq_ctrl;
`ifdef ADC_SEQ_AVG_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cfg_enable, cfg_single, err_clear, adc_busy, adc_done;
   logic [15:0] cfg_period, adc_raw, adc_data_value;
   logic [1:0]  cfg_avg_log2;
   logic        adc_start, adc_data_valid, busy, err_timeout;
   logic [7:0]  ovr_count;

   adc_seq_ctrl #(.TIMEOUT_CYCLES(1024), .PERIOD_MIN(4)) dut (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
      .cfg_single(cfg_single), .cfg_avg_log2(cfg_avg_log2), .err_clear(err_clear),
      .adc_busy(adc_busy), .adc_done(adc_done), .adc_raw(adc_raw),
      .adc_start(adc_start), .adc_data_value(adc_data_value), .adc_data_valid(adc_data_valid),
      .busy(busy), .err_timeout(err_timeout), .ovr_count(ovr_count)
   );

   typedef struct {
      logic [1:0]       lg;
      logic [3:0][15:0] r;
      logic [15:0]      per;
      logic [15:0]      ev;
      int               ns;
   } vec_t;

   int total = 0, bad = 0;
   int cyc = 0, starts = 0, vcount = 0, viol = 0, done_cyc = -10, lat = 5, pcnt = 0, ri = 0;
   bit model_on = 1'b1, use_tbl = 1'b1, exp_direct = 1'b0;
   logic [15:0] last_val = '0, last_raw = '0;
   logic [3:0][15:0] raws = '0;
   int st_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_busy(input logic lvl, input int maxc, input string nm);
      int n;
      n = 0;
      while (busy !== lvl && n < maxc) begin
         tick(1);
         n++;
      end
      if (busy !== lvl) chk(nm, busy, lvl);
   endtask

   task automatic wait_starts(input int k, input int maxc, input string nm);
      int n;
      n = 0;
      while (starts < k && n < maxc) begin
         tick(1);
         n++;
      end
      if (starts < k) chk(nm, starts, k);
   endtask

   task automatic pulse_single();
      cfg_single = 1'b1;
      tick(1);
      cfg_single = 1'b0;
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
   endtask

   // Monitor first (outputs of the current cycle), then drive the ADC model for this cycle.
   initial begin
      adc_done = 1'b0;
      adc_raw  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (adc_data_valid === 1'b1) begin
            vcount++;
            last_val = adc_data_value;
            chk("valid_latency", cyc - done_cyc, 1);
            if (exp_direct) chk("direct_value", adc_data_value, last_raw);
         end
         if (adc_start === 1'b1) begin
            starts++;
            st_q.push_back(cyc);
            if (adc_busy) viol++;
         end
         adc_done = 1'b0;
         if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) begin
               adc_done = 1'b1;
               adc_raw  = use_tbl ? raws[ri & 3] : 16'(ri * 37 + 5);
               last_raw = adc_raw;
               done_cyc = cyc;
               ri++;
            end
         end
         if (adc_start === 1'b1 && model_on) pcnt = lat;
      end
   end

   initial begin
      vec_t tbl[5];
      int v0, s, fcyc;
      tbl[0] = '{2'd2, {16'd41, 16'd30, 16'd20, 16'd10}, 16'd30, AVG ? 16'd25 : 16'd10, AVG ? 4 : 1};
      tbl[1] = '{2'd0, {16'd0, 16'd0, 16'd0, 16'd1234}, 16'd30, 16'd1234, 1};
      tbl[2] = '{2'd1, {16'd0, 16'd0, 16'd65535, 16'd65535}, 16'd30, 16'd65535, AVG ? 2 : 1};
      tbl[3] = '{2'd1, {16'd0, 16'd0, 16'd8, 16'd7}, 16'd30, 16'd7, AVG ? 2 : 1};
      tbl[4] = '{2'd2, {16'd65535, 16'd65535, 16'd65535, 16'd65535}, 16'd8, 16'd65535, AVG ? 4 : 1};

      rst = 1'b1; cfg_enable = 1'b0; cfg_single = 1'b0; err_clear = 1'b0; adc_busy = 1'b0;
      cfg_period = 16'd100; cfg_avg_log2 = 2'd0;
      tick(3);
      chk("rst_start", adc_start, 0);
      chk("rst_valid", adc_data_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_ovr", ovr_count, 0);
      chk("rst_value", adc_data_value, 0);
      rst = 1'b0;
      tick(2);

      // Single-shot conversions from the table
      lat = 5;
      use_tbl = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cfg_avg_log2 = tbl[i].lg;
         cfg_period   = tbl[i].per;
         raws         = tbl[i].r;
         ri = 0; starts = 0; v0 = vcount;
         pulse_single();
         wait_busy(1'b1, 10, $sformatf("tbl%0d_busy_rise", i));
         wait_busy(1'b0, 1000, $sformatf("tbl%0d_busy_fall", i));
         tick(2);
         chk($sformatf("tbl%0d_nvalid", i), vcount - v0, 1);
         chk($sformatf("tbl%0d_value", i), last_val, tbl[i].ev);
         chk($sformatf("tbl%0d_starts", i), starts, tbl[i].ns);
         chk($sformatf("tbl%0d_idle", i), busy, 0);
      end

      // Free-running, period 100, done after 20
      use_tbl = 1'b0; ri = 0; lat = 20; exp_direct = 1'b1;
      cfg_period = 16'd100; cfg_avg_log2 = 2'd0;
      starts = 0; st_q.delete(); v0 = vcount;
      cfg_enable = 1'b1;
      wait_starts(4, 500, "per_start_timeout");
      for (int k = 1; k < 4; k++) chk("per_interval", st_q[k] - st_q[k-1], 100);
      cfg_enable = 1'b0;
      wait_busy(1'b0, 300, "per_idle_timeout");
      tick(2);
      exp_direct = 1'b0;
      chk("per_nvalid", vcount - v0, 4);
      chk("per_ovr", ovr_count, 0);

      // Period clamp and overrun saturation
      pulse_clear();
      lat = 10; cfg_period = 16'd2;
      starts = 0; st_q.delete();
      cfg_enable = 1'b1;
      wait_starts(5, 200, "ovr_start_timeout");
      chk("ovr_after4", ovr_count, 4);
      chk("ovr_interval", st_q[4] - st_q[3], 11);
      wait_starts(262, 4000, "ovr_sat_timeout");
      chk("ovr_saturated", ovr_count, 255);
      cfg_enable = 1'b0;
      wait_busy(1'b0, 100, "ovr_idle_timeout");
      pulse_clear();
      chk("ovr_cleared", ovr_count, 0);

      // adc_busy holding off a due start
      lat = 3; cfg_period = 16'd20;
      starts = 0; st_q.delete();
      cfg_enable = 1'b1;
      wait_starts(1, 50, "hold_start_timeout");
      tick(5);
      adc_busy = 1'b1;
      tick(50);
      adc_busy = 1'b0;
      fcyc = cyc;
      wait_starts(2, 50, "hold_release_timeout");
      chk("hold_start_cycle", st_q[1] - fcyc, 1);
      chk("hold_no_start_busy", viol, 0);
      cfg_enable = 1'b0;
      wait_busy(1'b0, 100, "hold_idle_timeout");

      // WAIT timeout, then same-cycle clear/set
      model_on = 1'b0; v0 = vcount; starts = 0;
      pulse_single();
      wait_starts(1, 10, "tmo_start_timeout");
      tick(1024);
      chk("tmo_err_before", err_timeout, 0);
      chk("tmo_busy_before", busy, 1);
      tick(1);
      chk("tmo_err_set", err_timeout, 1);
      chk("tmo_idle", busy, 0);
      tick(5);
      chk("tmo_stays_idle", busy, 0);
      pulse_clear();
      chk("tmo_err_clear", err_timeout, 0);
      pulse_single();
      wait_starts(2, 10, "tmo2_start_timeout");
      tick(1024);
      pulse_clear();
      chk("tmo_set_wins", err_timeout, 1);
      pulse_clear();
      chk("tmo_err_clear2", err_timeout, 0);
      chk("tmo_no_valid", vcount - v0, 0);
      model_on = 1'b1;

      // Reset in WAIT with a late adc_done
      lat = 20; cfg_period = 16'd100; starts = 0;
      cfg_enable = 1'b1;
      wait_starts(1, 20, "rstw_start_timeout");
      tick(5);
      rst = 1'b1; cfg_enable = 1'b0;
      tick(1);
      rst = 1'b0;
      v0 = vcount;
      tick(30);
      chk("rstw_no_valid", vcount - v0, 0);
      chk("rstw_value", adc_data_value, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_start", adc_start, 0);
      chk("rstw_err", err_timeout, 0);
      chk("rstw_ovr", ovr_count, 0);

      // cfg_enable falling mid-average
      lat = 3; cfg_period = 16'd20; cfg_avg_log2 = 2'd2; starts = 0; v0 = vcount;
      cfg_enable = 1'b1;
      wait_starts(2, 100, "drop_start_timeout");
      cfg_enable = 1'b0;
      wait_busy(1'b0, 100, "drop_idle_timeout");
      tick(2);
      chk("drop_nvalid", vcount - v0, AVG ? 0 : 2);
      chk("drop_starts", starts, 2);
      chk("drop_idle", busy, 0);
      use_tbl = 1'b1; raws = {16'd0, 16'd0, 16'd0, 16'd500}; ri = 0; cfg_avg_log2 = 2'd0;
      pulse_single();
      wait_busy(1'b1, 10, "after_drop_rise");
      wait_busy(1'b0, 200, "after_drop_fall");
      tick(2);
      chk("after_drop_value", last_val, 500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adc_seq_ctrl.md
ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: max clocks waiting for adc_done before a timeout.
REQ-002 The block SHALL have parameter PERIOD_MIN, default 4: floor applied to cfg_period.
REQ-003 Port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port cfg_enable  in  1  level; high = free-running periodic conversions.
REQ-006 Port cfg_period  in  16  clocks between successive adc_start pulses.
REQ-007 Port cfg_single  in  1  one-cycle pulse; request one conversion (one averaged result).
REQ-008 Port cfg_avg_log2  in  2  samples per result = 2^cfg_avg_log2.
REQ-009 Port err_clear  in  1  pulse; clears err_timeout and ovr_count.
REQ-010 Port adc_busy  in  1  ADC busy; no start is issued while high.
REQ-011 Port adc_done  in  1  one-cycle pulse; adc_raw is valid.
REQ-012 Port adc_raw  in  16  conversion result.
REQ-013 Port adc_start  out  1  one-cycle conversion start pulse.
REQ-014 Port adc_data_value  out  16  last published result; held between updates.
REQ-015 Port adc_data_valid  out  1  one-cycle pulse per published result.
REQ-016 Port busy  out  1  high in any state other than IDLE.
REQ-017 Port err_timeout  out  1  sticky timeout flag.
REQ-018 Port ovr_count  out  8  saturating count of missed period ticks.

Function
REQ-019 The FSM SHALL have states IDLE, START, WAIT and SPACE.
REQ-020 IDLE SHALL go to START when adc_busy=0 and either (cfg_enable=1) or (cfg_single pending).
REQ-021 cfg_single SHALL be latched into a pending bit while cfg_enable=0; it is ignored while cfg_enable=1.
REQ-022 START SHALL assert adc_start for exactly one cycle, load the period counter with max(cfg_period, PERIOD_MIN)-1, and go to WAIT.
REQ-023 In WAIT, adc_done SHALL add adc_raw to a 19-bit accumulator, increment the sample count, and go to SPACE.
REQ-024 adc_done outside WAIT SHALL be ignored.
REQ-025 A result SHALL be published when the sample count reaches 2^cfg_avg_log2: adc_data_value = accumulator >> cfg_avg_log2, adc_data_valid pulsed one cycle after adc_done, then accumulator and count cleared.
REQ-026 SPACE SHALL wait for the period counter to reach 0.
REQ-027 From SPACE, the FSM SHALL return to START if cfg_enable=1, or if a single request is mid-average; otherwise it SHALL go to IDLE, clearing the single pending bit on publish.
REQ-028 If the period counter expires while in WAIT, ovr_count SHALL increment (saturate at 255); the next start is issued immediately after adc_done, subject to adc_busy=0.
REQ-029 adc_start SHALL never be asserted while adc_busy=1; START is delayed until adc_busy=0.
REQ-030 A WAIT timeout counter SHALL be used: after TIMEOUT_CYCLES cycles without adc_done, set err_timeout, discard the accumulator, and go to IDLE.
REQ-031 If err_clear and a timeout occur in the same cycle, the set SHALL win.
REQ-032 If cfg_enable falls mid-conversion, the current conversion SHALL complete; then go to IDLE, and a partial average is discarded with no valid pulse.
REQ-033 cfg_avg_log2 and cfg_period SHALL be sampled in START; changes mid-average take effect at the next result boundary.

Reset
REQ-034 On rst=1, the FSM SHALL go to IDLE, and adc_start, adc_data_valid, busy, err_timeout, ovr_count, adc_data_value, accumulator, counters and the pending bit SHALL be 0, on the next clock edge.
REQ-035 Reset asserted mid-conversion SHALL abandon the conversion; any adc_done arriving after reset release SHALL be ignored.

Configuration
REQ-036 With macro ADC_SEQ_AVG_EN defined, averaging SHALL be per REQ-023/025.
REQ-037 Without ADC_SEQ_AVG_EN, cfg_avg_log2 SHALL be ignored (treated as 0), the accumulator SHALL be removed, and every adc_done SHALL publish adc_raw directly with 1-cycle latency.

Structure
REQ-038 Package adc_seq_pkg SHALL hold the state enum, PERIOD_MIN and TIMEOUT_CYCLES defaults, ACC_W=19 and DATA_W=16.
REQ-039 Sub-module adc_seq_avg SHALL contain the accumulator, sample counter and shift; it is instantiated only under ADC_SEQ_AVG_EN.

Verification
REQ-040 Bench: enable=1, period=100, avg_log2=0, ADC done after 20 clks -> adc_start every 100 clks; each adc_raw appears on adc_data_value 1 clk after done; ovr_count=0.
REQ-041 Bench: single pulse, avg_log2=2, raws 10,20,30,41 -> exactly 4 starts, one valid pulse, value 25, then IDLE with busy=0.
REQ-042 Bench: period=2 -> clamped to 4-clk spacing; ADC done latency 10 -> ovr_count increments each conversion, saturating at 255.
REQ-043 Bench: TIMEOUT_CYCLES=1024, adc_done withheld -> err_timeout=1 at cycle 1024 of WAIT, FSM in IDLE; err_clear -> 0.
REQ-044 Bench: adc_busy held high for 50 clks at a due start -> adc_start held off, issued the cycle after busy falls.
REQ-045 Bench: rst pulsed in WAIT, then a late adc_done -> all outputs 0, no valid pulse; cfg_enable=0 mid-average -> no valid pulse, IDLE.
